// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier control unit: FSM states, y/f bit
// indices and the decode helper for an "accumulate +/-A into RR" step.
package mult_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    INIT,
    SHIFT,
    ADD,
    CORR,
    NZ,
    FLAG,
    DONE
  } state_e;

  localparam int Y_LD_RA  = 1;
  localparam int Y_RB_SEL = 2;
  localparam int Y_RB_EN  = 3;
  localparam int Y_ADD_A  = 4;
  localparam int Y_SUB_A  = 5;
  localparam int Y_RR_SEL = 6;
  localparam int Y_RR_EN  = 7;
  localparam int Y_RR_CLR = 8;
  localparam int Y_FB_RR  = 9;
  localparam int Y_LD_PR  = 10;

  localparam int F_SIGN = 0;
  localparam int F_BIT  = 1;
  localparam int F_NZ   = 2;

  // RR <= RR +/- A: adder fed back from RR, RR loaded from the adder.
  function automatic logic [10:1] y_accumulate(input logic subtract);
    logic [10:1] v;
    v = '0;
    if (subtract) v[Y_SUB_A] = 1'b1;
    else          v[Y_ADD_A] = 1'b1;
    v[Y_FB_RR]  = 1'b1;
    v[Y_RR_SEL] = 1'b1;
    v[Y_RR_EN]  = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mult_control_unit_step_counter.sv
// Iteration counter for the SHIFT/ADD loop; last is high on the increment
// that brings the count to N-1, and the count never wraps.
module step_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = inc && (cnt_d == CNT_MAX);

endmodule

// File: rtl/mult_control_unit.sv
// Control FSM for the N-bit ones'-complement multiplier datapath.
// Define NEG_ZERO_FIX_EN to include the NZ state that clears a -0 result.
module mult_control_unit
  import mult_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  f,
  output logic [10:1] y,
  output logic        busy,
  output logic        done
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  step_counter #(
    .N(N)
  ) u_step_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        cnt_clr = 1'b1;
        state_d = INIT;
      end
      INIT:  state_d = SHIFT;
      SHIFT: state_d = ADD;
      ADD: begin
        cnt_inc = 1'b1;
        state_d = cnt_last ? CORR : SHIFT;
      end
`ifdef NEG_ZERO_FIX_EN
      CORR:  state_d = NZ;
      NZ:    state_d = FLAG;
`else
      CORR:  state_d = FLAG;
`endif
      FLAG:  state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates y so a mid-operation reset cannot disturb datapath registers.
  always_comb begin
    y = '0;
    case (state_q)
      LOAD: begin
        y[Y_LD_RA]  = 1'b1;
        y[Y_RB_SEL] = 1'b1;
        y[Y_RB_EN]  = 1'b1;
        y[Y_RR_CLR] = 1'b1;
      end
      INIT:  if (f[F_SIGN]) y = y_accumulate(1'b1);
      SHIFT: y[Y_RR_EN] = 1'b1;
      ADD: begin
        if (f[F_BIT]) y = y_accumulate(1'b0);
        y[Y_RB_EN] = 1'b1;
      end
      CORR:  if (f[F_SIGN]) y = y_accumulate(1'b0);
`ifdef NEG_ZERO_FIX_EN
      NZ:    if (f[F_NZ]) y[Y_RR_CLR] = 1'b1;
`endif
      FLAG:  y[Y_LD_PR] = 1'b1;
      default: y = '0;
    endcase
    if (rst) y = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: random flags each cycle, outputs compared with
// a cycle-number reference of the control schedule.
module tb_mult_control_unit;

  localparam int N = 4;
`ifdef NEG_ZERO_FIX_EN
  localparam int LAST_K = 2 * N + 4;
`else
  localparam int LAST_K = 2 * N + 3;
`endif
  localparam int FLAG_K = LAST_K - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  f = 3'b000;
  logic [10:1] y;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;
  int k_m    = 0;
  int done_seen = 0;
  int done_exp  = 0;

  mult_control_unit #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .f     (f),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Control vector expected k cycles after start was accepted (k=0: idle).
  function automatic logic [10:1] exp_y(input int k, input logic [2:0] ff);
    logic [10:1] e;
    logic [10:1] acc;
    e = '0;
    acc = '0;
    acc[9] = 1'b1; acc[6] = 1'b1; acc[7] = 1'b1;
    if (k == 1) begin
      e[1] = 1'b1; e[2] = 1'b1; e[3] = 1'b1; e[8] = 1'b1;
    end else if (k == 2) begin
      if (ff[0]) begin e = acc; e[5] = 1'b1; end
    end else if (k >= 3 && k <= 2 * N) begin
      if (k % 2 == 1) e[7] = 1'b1;
      else begin
        if (ff[1]) begin e = acc; e[4] = 1'b1; end
        e[3] = 1'b1;
      end
    end else if (k == 2 * N + 1) begin
      if (ff[0]) begin e = acc; e[4] = 1'b1; end
    end else if (k == FLAG_K) begin
      e[10] = 1'b1;
`ifdef NEG_ZERO_FIX_EN
    end else if (k == 2 * N + 2) begin
      if (ff[2]) e[8] = 1'b1;
`endif
    end
    return e;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic st, input logic rs);
    logic [10:1] ey;
    start = st;
    rst   = rs;
    f     = 3'($urandom);
    @(negedge clk);
    ey = rs ? 10'b0 : exp_y(k_m, f);
    total++;
    assert (y === ey) passed++;
    else $error("FAIL y k=%0d rst=%0b f=%b: got %b expected %b", k_m, rs, f, y, ey);
    if (!rs) begin
      total++;
      assert (busy === (k_m != 0)) passed++;
      else $error("FAIL busy k=%0d: got %b expected %b", k_m, busy, (k_m != 0));
      total++;
      assert (done === (k_m == LAST_K)) passed++;
      else $error("FAIL done k=%0d: got %b expected %b", k_m, done, (k_m == LAST_K));
      if (done === 1'b1) done_seen++;
      if (k_m == LAST_K) done_exp++;
    end
    @(posedge clk);
    if (rs)                 k_m = 0;
    else if (k_m == 0)      k_m = st ? 1 : 0;
    else if (k_m == LAST_K) k_m = 0;
    else                    k_m = k_m + 1;
    #1;
  endtask

  task automatic check_done_count(input string tag);
    total++;
    assert (done_seen === done_exp) passed++;
    else $error("FAIL %s done pulses: got %0d expected %0d", tag, done_seen, done_exp);
    done_seen = 0;
    done_exp  = 0;
  endtask

  initial begin
    // Power-on reset
    repeat (3) cycle(1'b0, 1'b1);

    // Idle with start low for 20 cycles
    repeat (20) cycle(1'b0, 1'b0);
    check_done_count("idle");

    // Single operation, start pulsed once
    cycle(1'b1, 1'b0);
    repeat (LAST_K + 3) cycle(1'b0, 1'b0);
    check_done_count("single");

    // Extra start pulses in cycle 3 and in the DONE cycle are ignored
    cycle(1'b1, 1'b0);
    for (int c = 1; c <= LAST_K + 3; c++) cycle((c == 3) || (c == LAST_K), 1'b0);
    check_done_count("ignored_start");

    // Level-held start: back-to-back operations
    repeat (3 * (LAST_K + 1)) cycle(1'b1, 1'b0);
    repeat (LAST_K + 2) cycle(1'b0, 1'b0);
    check_done_count("held_start");

    // Reset in cycle 6, then a fresh operation
    cycle(1'b1, 1'b0);
    for (int c = 1; c < 6; c++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (LAST_K + 2) cycle(1'b0, 1'b0);
    check_done_count("mid_reset");

    // Random start and occasional reset
    for (int c = 0; c < 400; c++)
      cycle(($urandom_range(3) == 0), ($urandom_range(40) == 0));
    check_done_count("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
